// File: rtl/pe_psum_acc_pkg.sv
// Shared configuration and state encoding for the PE partial-sum accumulator.
// Sizes track the adder-tree output width and the accumulator/result width.
package pe_psum_acc_pkg;

  localparam int unsigned ASUMDWD   = 16;
  localparam int unsigned PSUMDWD   = 24;
  localparam int unsigned PSUMCNTWD = 8;

  typedef enum logic [1:0] {
    ACC_IDLE,
    ACC_RUN,
    ACC_OUT
  } acc_state_t;

endpackage

// File: rtl/pe_psum_acc_sat_add.sv
// Combinational signed a + sext(b), clamped to the AWD-bit signed range.
// ovf flags that the clamp was applied; assumes BWD <= AWD.
module pe_sat_add #(
  parameter int unsigned AWD = 24,
  parameter int unsigned BWD = 16
) (
  input  logic [AWD-1:0] a,
  input  logic [BWD-1:0] b,
  output logic [AWD-1:0] sum,
  output logic           ovf
);

  localparam int unsigned EXT = AWD + 1 - BWD;

  logic [AWD:0]   full;
  logic [AWD-1:0] max_val;
  logic [AWD-1:0] min_val;

  assign max_val = {1'b0, {(AWD-1){1'b1}}};
  assign min_val = {1'b1, {(AWD-1){1'b0}}};

  always_comb begin
    full = {a[AWD-1], a} + {{EXT{b[BWD-1]}}, b};
    ovf  = full[AWD] ^ full[AWD-1];
    sum  = full[AWD-1:0];
    // Sign of the wide result tells which rail was crossed.
    if (ovf) begin
      sum = full[AWD] ? min_val : max_val;
    end
  end

endmodule

// File: rtl/pe_psum_acc.sv
// Accumulates a configured number of signed partial sums from an init value and
// hands one saturated result per job to the output buffer over valid/ready.
module pe_psum_acc
  import pe_psum_acc_pkg::*;
#(
  parameter int unsigned IDWD  = ASUMDWD,
  parameter int unsigned ACCWD = PSUMDWD,
  parameter int unsigned CNTWD = PSUMCNTWD
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [CNTWD-1:0] i_len,
  input  logic [ACCWD-1:0] i_init,
  input  logic             i_flush,
  output logic             o_idle,
  input  logic             i_sum_valid,
  output logic             o_sum_ready,
  input  logic [IDWD-1:0]  i_sum,
  output logic             o_psum_valid,
  input  logic             i_psum_ready,
  output logic [ACCWD-1:0] o_psum,
  output logic             o_sat
);

  acc_state_t       state;
  logic [ACCWD-1:0] acc;
  logic [CNTWD-1:0] cnt;
  logic [CNTWD-1:0] len;
  logic             sat_seen;

  logic [ACCWD-1:0] add_sum;
  logic             add_ovf;
  logic             beat;
  logic             load;
  logic             last;

  pe_sat_add #(
    .AWD(ACCWD),
    .BWD(IDWD)
  ) u_sat_add (
    .a  (acc),
    .b  (i_sum),
    .sum(add_sum),
    .ovf(add_ovf)
  );

  assign o_idle       = (state == ACC_IDLE);
  assign o_sum_ready  = (state == ACC_RUN);
  assign o_psum_valid = (state == ACC_OUT);

  assign beat = o_sum_ready && i_sum_valid;
  // Compare before increment so len = all-ones never needs a wider counter.
  assign last = (cnt == len);
  assign load = i_start && (o_idle || (o_psum_valid && i_psum_ready));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= ACC_IDLE;
      acc      <= '0;
      cnt      <= '0;
      len      <= '0;
      sat_seen <= 1'b0;
      o_psum   <= '0;
      o_sat    <= 1'b0;
    end else if (i_flush) begin
      state    <= ACC_IDLE;
      acc      <= '0;
      cnt      <= '0;
      sat_seen <= 1'b0;
    end else begin
      case (state)
        ACC_IDLE: begin
          if (load) begin
            state    <= ACC_RUN;
            acc      <= i_init;
            len      <= i_len;
            cnt      <= '0;
            sat_seen <= 1'b0;
          end
        end
        ACC_RUN: begin
          if (beat) begin
            acc      <= add_sum;
            sat_seen <= sat_seen | add_ovf;
            cnt      <= cnt + CNTWD'(1);
            if (last) begin
              state  <= ACC_OUT;
              o_psum <= add_sum;
              o_sat  <= sat_seen | add_ovf;
            end
          end
        end
        ACC_OUT: begin
          if (i_psum_ready) begin
            if (load) begin
              state    <= ACC_RUN;
              acc      <= i_init;
              len      <= i_len;
              cnt      <= '0;
              sat_seen <= 1'b0;
            end else begin
              state <= ACC_IDLE;
            end
          end
        end
        default: state <= ACC_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_psum_acc.sv
// Scoreboard bench for pe_psum_acc: jobs push modelled results, the output
// monitor pops and compares them on each accepted result.
module tb_pe_psum_acc;

  localparam longint SMAX = 8388607;
  localparam longint SMIN = -8388608;

  typedef struct {
    logic [23:0] psum;
    logic        sat;
  } exp_t;

  logic        clk;
  logic        i_rst;
  logic        i_start;
  logic [7:0]  i_len;
  logic [23:0] i_init;
  logic        i_flush;
  logic        o_idle;
  logic        i_sum_valid;
  logic        o_sum_ready;
  logic [15:0] i_sum;
  logic        o_psum_valid;
  logic        i_psum_ready;
  logic [23:0] o_psum;
  logic        o_sat;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_e;

  pe_psum_acc #(
    .IDWD (16),
    .ACCWD(24),
    .CNTWD(8)
  ) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_len       (i_len),
    .i_init      (i_init),
    .i_flush     (i_flush),
    .o_idle      (o_idle),
    .i_sum_valid (i_sum_valid),
    .o_sum_ready (o_sum_ready),
    .i_sum       (i_sum),
    .o_psum_valid(o_psum_valid),
    .i_psum_ready(i_psum_ready),
    .o_psum      (o_psum),
    .o_sat       (o_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result monitor: a handshake that will complete at the next rising edge.
  always @(negedge clk) begin
    if (!i_rst && !i_flush && o_psum_valid && i_psum_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got psum %0d with no job pending", $signed(o_psum));
      end else begin
        mon_e = sb.pop_front();
        if (o_psum !== mon_e.psum || o_sat !== mon_e.sat) begin
          errors++;
          $display("FAIL sb_result: got psum %0d sat %0b, expected psum %0d sat %0b",
                   $signed(o_psum), o_sat, $signed(mon_e.psum), mon_e.sat);
        end
      end
    end
  end

  task automatic model_job(input longint init, input int sums[$], output exp_t e);
    longint a;
    logic   s;
    a = init;
    s = 1'b0;
    foreach (sums[i]) begin
      a = a + longint'(sums[i]);
      if (a > SMAX) begin
        a = SMAX;
        s = 1'b1;
      end else if (a < SMIN) begin
        a = SMIN;
        s = 1'b1;
      end
    end
    e.psum = 24'(a);
    e.sat  = s;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int init, input int len);
    i_start = 1'b1;
    i_init  = 24'(init);
    i_len   = 8'(len);
    tick();
    i_start = 1'b0;
  endtask

  task automatic beat(input int s);
    i_sum_valid = 1'b1;
    i_sum       = 16'(s);
    tick();
    i_sum_valid = 1'b0;
    i_sum       = 16'h7fff;
  endtask

  task automatic gap();
    i_sum_valid = 1'b0;
    i_sum       = 16'h1234;
    tick();
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    i_start = 1'b0; i_len = '0; i_init = '0; i_flush = 1'b0;
    i_sum_valid = 1'b0; i_sum = '0; i_psum_ready = 1'b0;
    repeat (2) tick();
    checks++;
    if (o_idle !== 1'b1) begin errors++; $display("FAIL rst_idle: got %0b expected 1", o_idle); end
    checks++;
    if (o_sum_ready !== 1'b0) begin errors++; $display("FAIL rst_sum_ready: got %0b expected 0", o_sum_ready); end
    checks++;
    if (o_psum_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b expected 0", o_psum_valid); end
    checks++;
    if (o_psum !== 24'd0 || o_sat !== 1'b0) begin
      errors++; $display("FAIL rst_psum: got %0d sat %0b expected 0 sat 0", $signed(o_psum), o_sat);
    end
    i_rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int   sums[$];
    exp_t e;
    sums = '{10, -20, 30, 40};
    model_job(100, sums, e);
    sb.push_back(e);
    i_psum_ready = 1'b1;
    start_job(100, 3);
    checks++;
    if (o_sum_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %0b expected 1", o_sum_ready); end
    beat(10); beat(-20); beat(30);
    checks++;
    if (o_psum_valid !== 1'b0) begin errors++; $display("FAIL single_early: got %0b expected 0", o_psum_valid); end
    beat(40);
    checks++;
    if (o_psum_valid !== 1'b1 || o_psum !== e.psum) begin
      errors++; $display("FAIL single_latency: got valid %0b psum %0d expected 1 %0d", o_psum_valid, $signed(o_psum), $signed(e.psum));
    end
    tick();
    checks++;
    if (o_idle !== 1'b1) begin errors++; $display("FAIL single_done_idle: got %0b expected 1", o_idle); end
  endtask

  task automatic test_sat();
    int   sums[$];
    exp_t e;
    i_psum_ready = 1'b1;
    sums = '{5, 5};
    model_job(8388600, sums, e);
    sb.push_back(e);
    start_job(8388600, 1);
    beat(5); beat(5);
    checks++;
    if (o_psum !== 24'h7fffff || o_sat !== 1'b1) begin
      errors++; $display("FAIL sat_pos: got %0d sat %0b expected 8388607 sat 1", $signed(o_psum), o_sat);
    end
    tick();
    sums = '{-10, 3};
    model_job(-8388600, sums, e);
    sb.push_back(e);
    start_job(-8388600, 1);
    beat(-10); beat(3);
    checks++;
    if ($signed(o_psum) !== -24'sd8388605 || o_sat !== 1'b1) begin
      errors++; $display("FAIL sat_neg: got %0d sat %0b expected -8388605 sat 1", $signed(o_psum), o_sat);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int   sums[$];
    exp_t e;
    exp_t e2;
    sums = '{3, 4};
    model_job(50, sums, e);
    sb.push_back(e);
    i_psum_ready = 1'b0;
    start_job(50, 1);
    beat(3); beat(4);
    for (int i = 0; i < 5; i++) begin
      // A start while the result is still pending must not load anything.
      i_start = (i >= 2);
      i_init  = 24'd999;
      i_len   = 8'd5;
      checks++;
      if (o_psum_valid !== 1'b1 || o_psum !== e.psum || o_sum_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold: cycle %0d got valid %0b psum %0d ready %0b expected 1 %0d 0",
                           i, o_psum_valid, $signed(o_psum), o_sum_ready, $signed(e.psum));
      end
      tick();
    end
    sums = '{1};
    model_job(7, sums, e2);
    sb.push_back(e2);
    i_start = 1'b1; i_init = 24'd7; i_len = 8'd0; i_psum_ready = 1'b1;
    tick();
    i_start = 1'b0;
    checks++;
    if (o_sum_ready !== 1'b1 || o_idle !== 1'b0) begin
      errors++; $display("FAIL b2b_no_bubble: got ready %0b idle %0b expected 1 0", o_sum_ready, o_idle);
    end
    beat(1);
    checks++;
    if (o_psum_valid !== 1'b1 || o_psum !== 24'd8) begin
      errors++; $display("FAIL b2b_result: got valid %0b psum %0d expected 1 8", o_psum_valid, $signed(o_psum));
    end
    tick();
  endtask

  task automatic test_bubbles();
    int   sums[$];
    exp_t e;
    sums = '{1, 2, 3};
    model_job(-5, sums, e);
    sb.push_back(e);
    i_psum_ready = 1'b1;
    start_job(-5, 2);
    beat(1); gap(); gap(); beat(2); gap();
    checks++;
    if (o_psum_valid !== 1'b0 || o_sum_ready !== 1'b1) begin
      errors++; $display("FAIL bub_pending: got valid %0b ready %0b expected 0 1", o_psum_valid, o_sum_ready);
    end
    beat(3);
    checks++;
    if (o_psum_valid !== 1'b1 || o_psum !== 24'd1) begin
      errors++; $display("FAIL bub_result: got valid %0b psum %0d expected 1 1", o_psum_valid, $signed(o_psum));
    end
    tick();
  endtask

  task automatic test_flush();
    i_psum_ready = 1'b1;
    start_job(10, 3);
    beat(1); beat(2);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    checks++;
    if (o_idle !== 1'b1 || o_psum_valid !== 1'b0 || o_sum_ready !== 1'b0) begin
      errors++; $display("FAIL flush_run: got idle %0b valid %0b ready %0b expected 1 0 0", o_idle, o_psum_valid, o_sum_ready);
    end
    for (int i = 0; i < 4; i++) begin
      i_sum_valid = 1'b1;
      i_sum       = 16'd3;
      tick();
      checks++;
      if (o_psum_valid !== 1'b0 || o_idle !== 1'b1) begin
        errors++; $display("FAIL flush_quiet: cycle %0d got valid %0b idle %0b expected 0 1", i, o_psum_valid, o_idle);
      end
    end
    i_sum_valid = 1'b0;
    i_psum_ready = 1'b0;
    start_job(0, 0);
    beat(9);
    checks++;
    if (o_psum_valid !== 1'b1) begin errors++; $display("FAIL flush_pre_out: got %0b expected 1", o_psum_valid); end
    i_flush = 1'b1; i_psum_ready = 1'b1; i_start = 1'b1; i_init = 24'd1; i_len = 8'd0;
    tick();
    i_flush = 1'b0; i_start = 1'b0;
    checks++;
    if (o_psum_valid !== 1'b0 || o_idle !== 1'b1) begin
      errors++; $display("FAIL flush_out: got valid %0b idle %0b expected 0 1", o_psum_valid, o_idle);
    end
    tick();
  endtask

  task automatic test_async_reset();
    i_psum_ready = 1'b0;
    start_job(8388607, 0);
    beat(1);
    checks++;
    if (o_psum_valid !== 1'b1 || o_sat !== 1'b1) begin
      errors++; $display("FAIL arst_pre: got valid %0b sat %0b expected 1 1", o_psum_valid, o_sat);
    end
    #2;
    i_rst = 1'b1;
    #1;
    checks++;
    if (o_psum_valid !== 1'b0 || o_psum !== 24'd0 || o_sat !== 1'b0 || o_sum_ready !== 1'b0 || o_idle !== 1'b1) begin
      errors++; $display("FAIL arst_now: got valid %0b psum %0d sat %0b ready %0b idle %0b expected 0 0 0 0 1",
                         o_psum_valid, $signed(o_psum), o_sat, o_sum_ready, o_idle);
    end
    tick();
    i_rst = 1'b0;
    tick();
  endtask

  task automatic test_ignored_start();
    int   sums[$];
    exp_t e;
    sums = '{4, 5, 6};
    model_job(0, sums, e);
    sb.push_back(e);
    i_psum_ready = 1'b1;
    start_job(0, 2);
    beat(4);
    i_start = 1'b1; i_init = 24'd999; i_len = 8'd0;
    beat(5);
    i_start = 1'b0;
    beat(6);
    checks++;
    if (o_psum_valid !== 1'b1 || o_psum !== 24'd15) begin
      errors++; $display("FAIL ign_result: got valid %0b psum %0d expected 1 15", o_psum_valid, $signed(o_psum));
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      i_sum_valid = 1'b1;
      i_sum       = 16'd1;
      checks++;
      if (o_idle !== 1'b1 || o_psum_valid !== 1'b0) begin
        errors++; $display("FAIL ign_no_job: cycle %0d got idle %0b valid %0b expected 1 0", i, o_idle, o_psum_valid);
      end
      tick();
    end
    i_sum_valid = 1'b0;
  endtask

  task automatic test_max_len();
    int   sums[$];
    exp_t e;
    for (int i = 0; i < 256; i++) sums.push_back(1);
    model_job(0, sums, e);
    sb.push_back(e);
    i_psum_ready = 1'b1;
    start_job(0, 255);
    for (int i = 0; i < 255; i++) beat(1);
    checks++;
    if (o_psum_valid !== 1'b0) begin errors++; $display("FAIL maxlen_early: got %0b expected 0", o_psum_valid); end
    beat(1);
    checks++;
    if (o_psum_valid !== 1'b1 || o_psum !== 24'd256) begin
      errors++; $display("FAIL maxlen_result: got valid %0b psum %0d expected 1 256", o_psum_valid, $signed(o_psum));
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_sat();
    test_back_to_back();
    test_bubbles();
    test_flush();
    test_async_reset();
    test_ignored_start();
    test_max_len();
    repeat (2) tick();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_drained: got %0d results outstanding expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
